// File: rtl/nanorv32_irq_ctrl.sv
// Interrupt controller ahead of the flow-control stage: synchronises sources, latches
// edge/level pending bits, masks, prioritises and tracks the single in-service interrupt.
module nanorv32_irq_ctrl #(
  parameter int unsigned NB_IRQ      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_IRQ-1:0] irq_src,
  input  logic              reg_wr,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              irq,
  input  logic              irq_ack,
  input  logic              interrupt_state_r,
  output logic [4:0]        irq_id,
  output logic              irq_active
);

  localparam int unsigned ID_W = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [1:0] A_ENABLE   = 2'd0;
  localparam logic [1:0] A_EDGE_SEL = 2'd1;
  localparam logic [1:0] A_PENDING  = 2'd2;
  localparam logic [1:0] A_STATUS   = 2'd3;

  logic [NB_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NB_IRQ-1:0] sync;
  logic [NB_IRQ-1:0] sync_d;
  logic [NB_IRQ-1:0] enable;
  logic [NB_IRQ-1:0] edge_sel;
  logic [NB_IRQ-1:0] pending;
  logic [NB_IRQ-1:0] pending_next;
  logic [NB_IRQ-1:0] rise;
  logic [NB_IRQ-1:0] w1c;
  logic [NB_IRQ-1:0] ack_clr;
  logic [NB_IRQ-1:0] cand;
  logic              cand_any;
  logic [ID_W-1:0]   cand_id;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   sel_next;
  logic [ID_W-1:0]   id_next;
  logic              ack_take;
  logic              int_state_d;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Input synchroniser chain plus one extra delay for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
      sync_d <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_d <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~sync_d;
  assign w1c  = (reg_wr && reg_addr == A_PENDING) ? reg_wdata[NB_IRQ-1:0] : '0;

  // Edge bits: a fresh rise beats any clear in the same cycle; level bits track sync
  assign pending_next = (edge_sel & ((pending & ~w1c & ~ack_clr) | rise))
                      | (~edge_sel & sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= '0;
      edge_sel <= '0;
      pending  <= '0;
    end else begin
      if (reg_wr && reg_addr == A_ENABLE)   enable   <= reg_wdata[NB_IRQ-1:0];
      if (reg_wr && reg_addr == A_EDGE_SEL) edge_sel <= reg_wdata[NB_IRQ-1:0];
      pending <= pending_next;
    end
  end

  assign cand     = pending & enable;
  assign cand_any = |cand;

  // Lowest set index wins
  always_comb begin
    cand_id = '0;
    for (int i = int'(NB_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) cand_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel_id      <= '0;
      irq_id      <= '0;
      irq         <= 1'b0;
      irq_active  <= 1'b0;
      int_state_d <= 1'b0;
    end else begin
      state       <= state_next;
      sel_id      <= sel_next;
      irq_id      <= id_next;
      irq         <= (state_next == ST_REQ);
      irq_active  <= (state_next == ST_ACTIVE);
      int_state_d <= interrupt_state_r;
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel_id;
    id_next    = irq_id;
    ack_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand_any) begin
          state_next = ST_REQ;
          sel_next   = cand_id;
        end
      end
      ST_REQ: begin
        if (!cand_any) begin
          state_next = ST_IDLE;
        end else if (irq_ack) begin
          state_next = ST_ACTIVE;
          id_next    = sel_id;
          ack_take   = 1'b1;
        end else begin
          sel_next = cand_id;
        end
      end
      ST_ACTIVE: begin
        // Handler done when flow control drops its interrupt state
        if (int_state_d && !interrupt_state_r) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ack_clr = ack_take ? (NB_IRQ'(1) << sel_id) : '0;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      A_ENABLE:   reg_rdata = 32'(enable);
      A_EDGE_SEL: reg_rdata = 32'(edge_sel);
      A_PENDING:  reg_rdata = 32'(pending);
      A_STATUS:   reg_rdata = {22'd0, irq, irq_active, 3'd0, irq_id};
      default:    reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Directed bench for nanorv32_irq_ctrl: latency, priority, masking, W1C races and reset.
module tb_nanorv32_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq;
  logic        irq_ack;
  logic        interrupt_state_r;
  logic [4:0]  irq_id;
  logic        irq_active;

  int errors = 0;
  int checks = 0;
  logic [31:0] rv;

  nanorv32_irq_ctrl #(.NB_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq), .irq_ack(irq_ack),
    .interrupt_state_r(interrupt_state_r), .irq_id(irq_id), .irq_active(irq_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_irq(input int max, input string name);
    int n = 0;
    while (irq !== 1'b1 && n < max) begin
      step();
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL %s: irq=%0b after %0d cycles, expected 1", name, irq, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_src = '0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    irq_ack = 1'b0; interrupt_state_r = 1'b0;
    step(); step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b want 0", irq); end
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %0b want 0", irq_active); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", a, rv); end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_edge();
    wr(2'd1, 32'h01);
    wr(2'd0, 32'h01);
    irq_src[0] = 1'b1;
    step();
    irq_src[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_early%0d: irq=%0b want 0", c, irq); end
      step();
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_lat4: irq=%0b want 1", irq); end
    rd(2'd2, rv);
    checks++; if (rv !== 32'h01) begin errors++; $display("FAIL edge_pend: got %h want 01", rv); end
    rd(2'd3, rv);
    checks++; if (rv !== 32'h200) begin errors++; $display("FAIL edge_status_req: got %h want 200", rv); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq: got %0b want 0", irq); end
    checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL ack_active: got %0b want 1", irq_active); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL ack_id: got %0d want 0", irq_id); end
    rd(2'd2, rv);
    checks++; if (rv !== 32'h00) begin errors++; $display("FAIL ack_pend: got %h want 00", rv); end
    interrupt_state_r = 1'b1;
    step();
    checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL hold_active: got %0b want 1", irq_active); end
    interrupt_state_r = 1'b0;
    step();
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL exit_active: got %0b want 0", irq_active); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL exit_irq: got %0b want 0", irq); end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h0C);
    irq_src[3] = 1'b1;
    wait_irq(8, "lvl3_req");
    irq_src[2] = 1'b1;
    repeat (5) step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_hold: irq=%0b want 1", irq); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq_id !== 5'd2) begin errors++; $display("FAIL prio_id: got %0d want 2", irq_id); end
    rd(2'd3, rv);
    checks++; if (rv !== 32'h102) begin errors++; $display("FAIL prio_status: got %h want 102", rv); end
    irq_src[2] = 1'b0;
    interrupt_state_r = 1'b1;
    repeat (4) step();
    interrupt_state_r = 1'b0;
    step();
    checks++; if (irq_active !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL prio_exit: active=%0b irq=%0b want 0 0", irq_active, irq);
    end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rereq3: irq=%0b want 1", irq); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq_id !== 5'd3) begin errors++; $display("FAIL rereq_id: got %0d want 3", irq_id); end
    irq_src[3] = 1'b0;
    interrupt_state_r = 1'b1;
    repeat (4) step();
    interrupt_state_r = 1'b0;
    step();
    repeat (3) step();
    checks++; if (irq !== 1'b0 || irq_active !== 1'b0) begin
      errors++; $display("FAIL lvl_quiet: irq=%0b active=%0b want 0 0", irq, irq_active);
    end
  endtask

  task automatic test_masked();
    wr(2'd0, 32'h00);
    wr(2'd1, 32'h20);
    irq_src[5] = 1'b1;
    step();
    irq_src[5] = 1'b0;
    repeat (4) step();
    rd(2'd2, rv);
    checks++; if (rv !== 32'h20) begin errors++; $display("FAIL mask_pend: got %h want 20", rv); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %0b want 0", irq); end
    wr(2'd0, 32'h20);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL unmask_1: irq=%0b want 0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_2: irq=%0b want 1", irq); end
    wr(2'd2, 32'h20);
    rd(2'd2, rv);
    checks++; if (rv !== 32'h00) begin errors++; $display("FAIL w1c_pend: got %h want 00", rv); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_idle: irq=%0b want 0", irq); end
  endtask

  task automatic test_same_cycle();
    wr(2'd0, 32'h00);
    wr(2'd1, 32'h02);
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    repeat (3) step();
    rd(2'd2, rv);
    checks++; if (rv !== 32'h02) begin errors++; $display("FAIL race_pre: got %h want 02", rv); end
    irq_src[1] = 1'b1;
    step();
    step();
    wr(2'd2, 32'h02);
    irq_src[1] = 1'b0;
    rd(2'd2, rv);
    checks++; if (rv !== 32'h02) begin errors++; $display("FAIL race_set_wins: got %h want 02", rv); end
    wr(2'd2, 32'h02);
    rd(2'd2, rv);
    checks++; if (rv !== 32'h00) begin errors++; $display("FAIL race_w1c: got %h want 00", rv); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0 || irq_active !== 1'b0) begin
      errors++; $display("FAIL idle_ack: irq=%0b active=%0b want 0 0", irq, irq_active);
    end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL idle_ack2: irq=%0b want 0", irq); end
  endtask

  task automatic test_reset_mid();
    wr(2'd0, 32'h02);
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    wait_irq(8, "rm_req");
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq_active !== 1'b1 || irq_id !== 5'd1) begin
      errors++; $display("FAIL rm_active: active=%0b id=%0d want 1 1", irq_active, irq_id);
    end
    interrupt_state_r = 1'b1;
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    repeat (4) step();
    rd(2'd2, rv);
    checks++; if (rv !== 32'h02) begin errors++; $display("FAIL rm_repend: got %h want 02", rv); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || irq_active !== 1'b0 || irq_id !== 5'd0) begin
      errors++; $display("FAIL rm_outs: irq=%0b active=%0b id=%0d want 0 0 0", irq, irq_active, irq_id);
    end
    rd(2'd2, rv);
    checks++; if (rv !== 32'h00) begin errors++; $display("FAIL rm_pend: got %h want 00", rv); end
    rd(2'd0, rv);
    checks++; if (rv !== 32'h00) begin errors++; $display("FAIL rm_enable: got %h want 00", rv); end
    interrupt_state_r = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wr(2'd1, 32'h02);
    wr(2'd0, 32'h02);
    repeat (4) step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rm_quiet: irq=%0b want 0", irq); end
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    wait_irq(8, "rm_new_event");
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_masked();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
